// File: rtl/countdown_timer_pkg.sv
// Shared types for the loadable countdown timer.
// Build with COUNTDOWN_AUTORELOAD_EN defined for periodic auto-reload.
package countdown_timer_pkg;

  localparam int COUNTDOWN_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_DEC  = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

endpackage

// File: rtl/countdown_timer_dec_reg.sv
// Count register for the countdown timer: per-bit async-clear flops
// behind a load / decrement / hold / clear mux.
module dflipflop (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

module dec_reg
  import countdown_timer_pkg::*;
#(
  parameter int N = COUNTDOWN_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  op_e          op_in,
  input  logic [N-1:0] load_in,
  output logic [N-1:0] count_q
);

  logic [N-1:0] count_d;

  always_comb begin
    count_d = count_q;
    unique case (op_in)
      OP_LOAD: count_d = load_in;
      OP_DEC:  count_d = count_q - N'(1);
      OP_CLR:  count_d = '0;
      default: count_d = count_q;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_bit
    dflipflop u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (count_d[i]),
      .q     (count_q[i])
    );
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/ready handshake and a done pulse.
// COUNTDOWN_AUTORELOAD_EN turns a run into a periodic tick until abort.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int N = COUNTDOWN_N
) (
  input  logic         clk,
  input  logic         reset_in_n,
  input  logic         start_in,
  input  logic [N-1:0] load_in,
  input  logic         en_in,
  input  logic         abort_in,
  output logic         ready,
  output logic         busy,
  output logic [N-1:0] count,
  output logic         done
);

  state_e       state_q, state_d;
  logic         done_q, done_d;
  op_e          op;
  logic [N-1:0] reg_load;
  logic [N-1:0] count_q;
  logic         last;

  assign last = (count_q == N'(1));

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [N-1:0] period_q, period_d;

  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) period_q <= '0;
    else             period_q <= period_d;
  end

  assign reg_load = (state_q == RUN) ? period_q : load_in;
`else
  assign reg_load = load_in;
`endif

  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    op      = OP_HOLD;
`ifdef COUNTDOWN_AUTORELOAD_EN
    period_d = period_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          op = OP_LOAD;
`ifdef COUNTDOWN_AUTORELOAD_EN
          period_d = load_in;
`endif
          // zero load is a zero-length run
          if (load_in != '0) state_d = RUN;
          else               done_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort_in) begin
          op      = OP_CLR;
          state_d = IDLE;
        end else if (en_in) begin
          if (!last) begin
            op = OP_DEC;
          end else begin
            done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            op = OP_LOAD;
`else
            op      = OP_CLR;
            state_d = IDLE;
`endif
          end
        end
      end
    endcase
  end

  dec_reg #(.N(N)) u_dec_reg (
    .clk     (clk),
    .rst_n   (reset_in_n),
    .op_in   (op),
    .load_in (reg_load),
    .count_q (count_q)
  );

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus random bench for countdown_timer against a
// run-length model (enabled cycles elapsed versus loaded length).
module tb_countdown_timer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_in;
  logic [N-1:0] load_in;
  logic         en_in;
  logic         abort_in;
  logic         ready;
  logic         busy;
  logic [N-1:0] count;
  logic         done;

  int vectors = 0;
  int errs    = 0;

  // model: running flag, run length, enabled cycles so far
  bit m_run;
  int m_len;
  int m_el;
  int m_cnt;
  bit m_done;

  countdown_timer #(.N(N)) dut (
    .clk        (clk),
    .reset_in_n (rst_n),
    .start_in   (start_in),
    .load_in    (load_in),
    .en_in      (en_in),
    .abort_in   (abort_in),
    .ready      (ready),
    .busy       (busy),
    .count      (count),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("count", 32'(count), 32'(m_cnt));
    chk("ready", 32'(ready), 32'(!m_run));
    chk("busy",  32'(busy),  32'(m_run));
    chk("done",  32'(done),  32'(m_done));
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_len  = 0;
    m_el   = 0;
    m_cnt  = 0;
    m_done = 0;
  endtask

  task automatic model_step(input bit st, input int ld,
                            input bit en, input bit ab);
    bit nd;
    nd = 0;
    if (!m_run) begin
      if (st) begin
        m_len = ld;
        m_el  = 0;
        m_cnt = ld;
        if (ld == 0) nd = 1;
        else         m_run = 1;
      end
    end else if (ab) begin
      m_run = 0;
      m_cnt = 0;
    end else if (en) begin
      m_el++;
      if (m_el == m_len) begin
        nd = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        m_el = 0;
`else
        m_run = 0;
`endif
      end
      m_cnt = m_run ? m_len - m_el : 0;
    end
    m_done = nd;
  endtask

  task automatic cycle(input bit st, input int ld,
                       input bit en, input bit ab);
    start_in = st;
    load_in  = N'(ld);
    en_in    = en;
    abort_in = ab;
    @(posedge clk);
    model_step(st, ld, en, ab);
    #1;
    chk_all();
  endtask

  initial begin
    rst_n    = 1'b0;
    start_in = 1'b0;
    load_in  = '0;
    en_in    = 1'b0;
    abort_in = 1'b0;
    model_reset();
    #1;
    chk_all();
    #2 rst_n = 1'b1;

    // basic run of 3
    cycle(1, 3, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);

    // gated run of 4
    cycle(1, 4, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 0);

    // zero-length run
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);

    // load 15, ignored start mid-run, abort on the terminal edge
    cycle(1, 15, 1, 0);
    for (int i = 0; i < 14; i++)
      cycle(i == 3, 9, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);

    // back-to-back start on the done cycle
    cycle(1, 2, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 2, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);

    // periodic patterns (one-shot in the default build)
    cycle(1, 3, 1, 0);
    repeat (8) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(1, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);

    // asynchronous reset mid-run at count 5
    cycle(1, 5, 1, 0);
    cycle(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    #1 rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit st, en, ab;
      int ld;
      st = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                       : $urandom_range(0, 4);
      en = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 15) == 0);
      cycle(st, ld, en, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
